// File: rtl/pwm_ramp_pkg.sv
// Shared types and constants for the PWM soft-start / soft-stop ramp controller.
package pwm_ramp_pkg;

    localparam int SPEED_W = 3;
    localparam logic [SPEED_W-1:0] SPEED_MAX = 3'd7;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2,
        STOP = 2'd3
    } ramp_state_t;

    // One level toward the target, saturating at 0 and SPEED_MAX.
    function automatic logic [SPEED_W-1:0] step_toward(
        input logic [SPEED_W-1:0] cur,
        input logic [SPEED_W-1:0] tgt
    );
        if ((tgt > cur) && (cur != SPEED_MAX)) return cur + 3'd1;
        if ((tgt < cur) && (cur != '0))        return cur - 3'd1;
        return cur;
    endfunction

endpackage

// File: rtl/pwm_speed_ramp_if.sv
// Pad-side request and PWM-side drive signals of the ramp controller.
// estop_n exists only when PWM_RAMP_ESTOP_EN is defined.
interface pwm_speed_ramp_if;
    import pwm_ramp_pkg::*;

    logic               run_req;
    logic [SPEED_W-1:0] target_speed;
    logic [SPEED_W-1:0] speed;
    logic               pwm_enable;
    logic               busy;
    logic               at_target;
`ifdef PWM_RAMP_ESTOP_EN
    logic               estop_n;

    modport master (output run_req, target_speed, estop_n,
                    input  speed, pwm_enable, busy, at_target);
    modport slave  (input  run_req, target_speed, estop_n,
                    output speed, pwm_enable, busy, at_target);
`else
    modport master (output run_req, target_speed,
                    input  speed, pwm_enable, busy, at_target);
    modport slave  (input  run_req, target_speed,
                    output speed, pwm_enable, busy, at_target);
`endif

endinterface

// File: rtl/ramp_tick_gen.sv
// Step prescaler: pulses tick every STEP_CYCLES clocks while run is high,
// restarting from zero whenever clear is asserted.
module ramp_tick_gen #(
    parameter int STEP_CYCLES = 50000,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = run && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || !run) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pwm_speed_ramp.sv
// Soft-start / soft-stop controller driving the PWM speed select and enable.
// Optional emergency stop input enabled by defining PWM_RAMP_ESTOP_EN.
//   state | meaning
//   OFF   | speed 0, PWM disabled, waiting for run
//   RAMP  | stepping speed toward target, one level per tick
//   HOLD  | speed equals target
//   STOP  | stepping down to 0 before releasing enable
module pwm_speed_ramp
    import pwm_ramp_pkg::*;
#(
    parameter int STEP_CYCLES = 50000,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    pwm_speed_ramp_if.slave  bus
);

    logic               run_m, run_s;
    logic [SPEED_W-1:0] tgt_m, tgt_s;

    ramp_state_t        state;
    logic [SPEED_W-1:0] speed_q;
    logic               pwm_en_q;
    logic               busy_q;
    logic               at_tgt_q;

    logic               tick;
    logic               clear;
    logic               run_cnt;
    logic               estop_act;
    logic               estop_blk;
    logic [SPEED_W-1:0] speed_step;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_m <= 1'b0;
            run_s <= 1'b0;
            tgt_m <= '0;
            tgt_s <= '0;
        end else begin
            run_m <= bus.run_req;
            run_s <= run_m;
            tgt_m <= bus.target_speed;
            tgt_s <= tgt_m;
        end
    end

`ifdef PWM_RAMP_ESTOP_EN
    logic est_m, est_s, est_latch;

    // Synchroniser resets to the released level so reset alone never trips the latch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            est_m     <= 1'b1;
            est_s     <= 1'b1;
            est_latch <= 1'b0;
        end else begin
            est_m <= bus.estop_n;
            est_s <= est_m;
            if (!est_s) begin
                est_latch <= 1'b1;
            end else if (!run_s) begin
                est_latch <= 1'b0;
            end
        end
    end

    assign estop_act = !est_s;
    assign estop_blk = est_latch;
`else
    assign estop_act = 1'b0;
    assign estop_blk = 1'b0;
`endif

    assign run_cnt    = (state == RAMP) || (state == STOP);
    assign speed_step = step_toward(speed_q, tgt_s);

    // Asserted exactly when the FSM is about to enter RAMP or STOP.
    always_comb begin
        clear = 1'b0;
        unique case (state)
            OFF:     clear = run_s && !estop_blk;
            RAMP:    clear = !run_s;
            HOLD:    clear = !run_s || (tgt_s != speed_q);
            STOP:    clear = run_s;
            default: clear = 1'b0;
        endcase
    end

    ramp_tick_gen #(
        .STEP_CYCLES (STEP_CYCLES),
        .CNT_W       (CNT_W)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .run   (run_cnt),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || estop_act) begin
            state    <= OFF;
            speed_q  <= '0;
            pwm_en_q <= 1'b0;
            busy_q   <= 1'b0;
            at_tgt_q <= 1'b0;
        end else begin
            unique case (state)
                OFF: begin
                    speed_q <= '0;
                    if (run_s && !estop_blk) begin
                        state    <= RAMP;
                        pwm_en_q <= 1'b1;
                        busy_q   <= 1'b1;
                        at_tgt_q <= 1'b0;
                    end
                end
                RAMP: begin
                    if (!run_s) begin
                        state <= STOP;
                    end else if (speed_q == tgt_s) begin
                        state    <= HOLD;
                        busy_q   <= 1'b0;
                        at_tgt_q <= 1'b1;
                    end else if (tick) begin
                        speed_q <= speed_step;
                        if (speed_step == tgt_s) begin
                            state    <= HOLD;
                            busy_q   <= 1'b0;
                            at_tgt_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!run_s) begin
                        state    <= STOP;
                        busy_q   <= 1'b1;
                        at_tgt_q <= 1'b0;
                    end else if (tgt_s != speed_q) begin
                        state    <= RAMP;
                        busy_q   <= 1'b1;
                        at_tgt_q <= 1'b0;
                    end
                end
                STOP: begin
                    if (run_s) begin
                        state <= RAMP;
                    end else if (speed_q == '0) begin
                        state    <= OFF;
                        pwm_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else if (tick) begin
                        speed_q <= speed_q - 3'd1;
                    end
                end
                default: begin
                    state    <= OFF;
                    speed_q  <= '0;
                    pwm_en_q <= 1'b0;
                    busy_q   <= 1'b0;
                    at_tgt_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.speed      = speed_q;
    assign bus.pwm_enable = pwm_en_q;
    assign bus.busy       = busy_q;
    assign bus.at_target  = at_tgt_q;

endmodule

// File: tb/tb_pwm_speed_ramp.sv
// Directed bench for pwm_speed_ramp with STEP_CYCLES=4; the estop sequence
// is included when PWM_RAMP_ESTOP_EN is defined.
module tb_pwm_speed_ramp;
    import pwm_ramp_pkg::*;

    localparam int STEP = 4;

    typedef struct {
        logic       run;
        logic [2:0] tgt;
        int         n;
        logic [2:0] e_speed;
        logic       e_pwm;
        logic       e_busy;
        logic       e_at;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    pwm_speed_ramp_if bus();

    pwm_speed_ramp #(
        .STEP_CYCLES (STEP),
        .CNT_W       (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check(input string name, input logic [2:0] es, input logic ep,
                         input logic eb, input logic ea);
        cmp({name, ".speed"},      int'(bus.speed),      int'(es));
        cmp({name, ".pwm_enable"}, int'(bus.pwm_enable), int'(ep));
        cmp({name, ".busy"},       int'(bus.busy),       int'(eb));
        cmp({name, ".at_target"},  int'(bus.at_target),  int'(ea));
    endtask

    initial begin
        // run, tgt, edges, speed, pwm, busy, at_target
        vq.push_back('{1'b1, 3'd5, 2, 3'd0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b1, 3'd5, 1, 3'd0, 1'b1, 1'b1, 1'b0});
        vq.push_back('{1'b1, 3'd5, 3, 3'd0, 1'b1, 1'b1, 1'b0});
        vq.push_back('{1'b1, 3'd5, 1, 3'd1, 1'b1, 1'b1, 1'b0});
        vq.push_back('{1'b1, 3'd5, 4, 3'd2, 1'b1, 1'b1, 1'b0});
        vq.push_back('{1'b1, 3'd5, 4, 3'd3, 1'b1, 1'b1, 1'b0});
        vq.push_back('{1'b1, 3'd5, 4, 3'd4, 1'b1, 1'b1, 1'b0});
        vq.push_back('{1'b1, 3'd5, 4, 3'd5, 1'b1, 1'b0, 1'b1});
        vq.push_back('{1'b1, 3'd5, 4, 3'd5, 1'b1, 1'b0, 1'b1});
        vq.push_back('{1'b1, 3'd2, 2, 3'd5, 1'b1, 1'b0, 1'b1});
        vq.push_back('{1'b1, 3'd2, 1, 3'd5, 1'b1, 1'b1, 1'b0});
        vq.push_back('{1'b1, 3'd2, 4, 3'd4, 1'b1, 1'b1, 1'b0});
        vq.push_back('{1'b1, 3'd2, 4, 3'd3, 1'b1, 1'b1, 1'b0});
        vq.push_back('{1'b1, 3'd2, 4, 3'd2, 1'b1, 1'b0, 1'b1});
        vq.push_back('{1'b1, 3'd3, 3, 3'd2, 1'b1, 1'b1, 1'b0});
        vq.push_back('{1'b1, 3'd3, 4, 3'd3, 1'b1, 1'b0, 1'b1});
        vq.push_back('{1'b0, 3'd3, 3, 3'd3, 1'b1, 1'b1, 1'b0});
        vq.push_back('{1'b0, 3'd3, 4, 3'd2, 1'b1, 1'b1, 1'b0});
        vq.push_back('{1'b1, 3'd3, 3, 3'd2, 1'b1, 1'b1, 1'b0});
        vq.push_back('{1'b1, 3'd3, 4, 3'd3, 1'b1, 1'b0, 1'b1});
        vq.push_back('{1'b0, 3'd3, 3, 3'd3, 1'b1, 1'b1, 1'b0});
        vq.push_back('{1'b0, 3'd3, 4, 3'd2, 1'b1, 1'b1, 1'b0});
        vq.push_back('{1'b0, 3'd3, 4, 3'd1, 1'b1, 1'b1, 1'b0});
        vq.push_back('{1'b0, 3'd3, 4, 3'd0, 1'b1, 1'b1, 1'b0});
        vq.push_back('{1'b0, 3'd3, 1, 3'd0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 3'd3, 4, 3'd0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b1, 3'd0, 3, 3'd0, 1'b1, 1'b1, 1'b0});
        vq.push_back('{1'b1, 3'd0, 1, 3'd0, 1'b1, 1'b0, 1'b1});
        vq.push_back('{1'b0, 3'd0, 3, 3'd0, 1'b1, 1'b1, 1'b0});
        vq.push_back('{1'b0, 3'd0, 1, 3'd0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b1, 3'd7, 3, 3'd0, 1'b1, 1'b1, 1'b0});
        vq.push_back('{1'b1, 3'd7, 4, 3'd1, 1'b1, 1'b1, 1'b0});
        vq.push_back('{1'b1, 3'd7, 4, 3'd2, 1'b1, 1'b1, 1'b0});
        vq.push_back('{1'b1, 3'd7, 4, 3'd3, 1'b1, 1'b1, 1'b0});
        vq.push_back('{1'b1, 3'd1, 4, 3'd2, 1'b1, 1'b1, 1'b0});
        vq.push_back('{1'b1, 3'd1, 4, 3'd1, 1'b1, 1'b0, 1'b1});

        // Reset held with an active request; outputs stay idle.
        bus.run_req      = 1'b1;
        bus.target_speed = 3'd7;
`ifdef PWM_RAMP_ESTOP_EN
        bus.estop_n      = 1'b1;
`endif
        rst_n = 1'b0;
        step(1);
        check("rst_0", 3'd0, 1'b0, 1'b0, 1'b0);
        step(1);
        check("rst_1", 3'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(1);
        check("rst_release", 3'd0, 1'b0, 1'b0, 1'b0);

        rst_n = 1'b0;
        bus.run_req      = 1'b0;
        bus.target_speed = 3'd0;
        step(1);
        rst_n = 1'b1;
        step(3);
        check("idle", 3'd0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vq.size(); i++) begin
            bus.run_req      = vq[i].run;
            bus.target_speed = vq[i].tgt;
            step(vq[i].n);
            check($sformatf("vec%0d", i), vq[i].e_speed, vq[i].e_pwm, vq[i].e_busy, vq[i].e_at);
        end

        // Reset while ramping at speed 4 drops everything on the next edge.
        bus.target_speed = 3'd7;
        step(3);
        check("rr_ramp", 3'd1, 1'b1, 1'b1, 1'b0);
        step(12);
        check("rr_at4", 3'd4, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        step(1);
        check("rr_reset", 3'd0, 1'b0, 1'b0, 1'b0);
        bus.run_req      = 1'b0;
        bus.target_speed = 3'd0;
        step(1);
        rst_n = 1'b1;
        step(3);
        check("rr_idle", 3'd0, 1'b0, 1'b0, 1'b0);

`ifdef PWM_RAMP_ESTOP_EN
        bus.run_req      = 1'b1;
        bus.target_speed = 3'd7;
        step(3);
        check("es_ramp", 3'd0, 1'b1, 1'b1, 1'b0);
        step(24);
        check("es_at6", 3'd6, 1'b1, 1'b1, 1'b0);
        bus.estop_n = 1'b0;
        step(2);
        check("es_pending", 3'd6, 1'b1, 1'b1, 1'b0);
        step(1);
        check("es_trip", 3'd0, 1'b0, 1'b0, 1'b0);
        bus.estop_n = 1'b1;
        step(6);
        check("es_latched", 3'd0, 1'b0, 1'b0, 1'b0);
        bus.run_req = 1'b0;
        step(3);
        check("es_unlatch", 3'd0, 1'b0, 1'b0, 1'b0);
        bus.run_req = 1'b1;
        step(3);
        check("es_restart", 3'd0, 1'b1, 1'b1, 1'b0);
        step(4);
        check("es_step1", 3'd1, 1'b1, 1'b1, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
